full_adder_st: RTL and testbench

FULL_ADDER_ST -- requirements
Module: full_adder_st

---
 rtl/full_adder_st.sv | 93 +++++++++
 tb/tb_full_adder_st.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/full_adder_st.sv
// Registered ripple-carry adder: WIDTH full-adder cells built from half adders,
// followed by one output register stage qualified by in_valid.

module full_adder_st_ha (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module full_adder_st_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic s_ab;
  logic c_ab;
  logic c_abc;

  full_adder_st_ha u_ha_ab (
    .a (a),
    .b (b),
    .s (s_ab),
    .c (c_ab)
  );

  full_adder_st_ha u_ha_abc (
    .a (s_ab),
    .b (ci),
    .s (s),
    .c (c_abc)
  );

  assign co = c_ab | c_abc;
endmodule

module full_adder_st #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             out_valid
);
  logic [WIDTH:0]   carry_p0;
  logic [WIDTH-1:0] sum_p0;
  logic [WIDTH-1:0] sum_p1;
  logic             cout_p1;
  logic             vld_p1;

  // Stage p0: combinational ripple chain, LSB to MSB.
  assign carry_p0[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder_st_fa u_cell (
      .a  (A[i]),
      .b  (B[i]),
      .ci (carry_p0[i]),
      .s  (sum_p0[i]),
      .co (carry_p0[i+1])
    );
  end

  // Stage p1: result register; data holds when the input is not valid.
  // Data is cleared by reset too, since outputs must read zero during reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_p1  <= '0;
      cout_p1 <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        sum_p1  <= sum_p0;
        cout_p1 <= carry_p0[WIDTH];
      end
    end
  end

  assign Sum       = sum_p1;
  assign Cout      = cout_p1;
  assign out_valid = vld_p1;
endmodule

// File: tb/tb_full_adder_st.sv
// Bench for full_adder_st: arithmetic reference model with per-cycle compare,
// directed literal checks, exhaustive stream and randomized traffic.

module tb_full_adder_st;
  localparam int WIDTH = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic             Cin = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             out_valid;

  int tests = 0;
  int fails = 0;
  bit checking = 1'b0;

  // Reference: the expected result word {Cout,Sum} as an integer, plus valid.
  int exp_res = 0;
  bit exp_vld = 1'b0;

  full_adder_st #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .in_valid  (in_valid),
    .Sum       (Sum),
    .Cout      (Cout),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_res = 0;
      exp_vld = 1'b0;
    end else begin
      exp_vld = in_valid;
      if (in_valid) exp_res = int'(A) + int'(B) + int'(Cin);
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("model_sum",   int'(Sum),       exp_res % (1 << WIDTH));
      check("model_cout",  int'(Cout),      exp_res / (1 << WIDTH));
      check("model_valid", int'(out_valid), int'(exp_vld));
    end
  end

  task automatic drive(input int a, input int b, input int c, input bit v);
    @(negedge clk);
    A = a[WIDTH-1:0];
    B = b[WIDTH-1:0];
    Cin = c[0];
    in_valid = v;
  endtask

  task automatic directed(input int a, input int b, input int c, input int s_exp, input int c_exp);
    drive(a, b, c, 1'b1);
    @(posedge clk);
    #1;
    check($sformatf("sum(%0d,%0d,%0d)", a, b, c), int'(Sum), s_exp);
    check($sformatf("cout(%0d,%0d,%0d)", a, b, c), int'(Cout), c_exp);
    check($sformatf("vld(%0d,%0d,%0d)", a, b, c), int'(out_valid), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-up reset, then enable the per-cycle compare.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checking = 1'b1;

    // Asynchronous reset while a valid (3,3) is presented and a result is held.
    directed(3, 3, 0, 2, 1);
    @(negedge clk);
    in_valid = 1'b1; A = 2'd3; B = 2'd3; Cin = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_sum",   int'(Sum),       0);
    check("rst_cout",  int'(Cout),      0);
    check("rst_valid", int'(out_valid), 0);
    #1 rst = 1'b0;
    #0.5;
    check("deassert_sum",   int'(Sum),       0);
    check("deassert_valid", int'(out_valid), 0);

    // Directed, Cin = 0 and Cin = 1.
    directed(3, 3, 0, 2, 1);
    check("pin_model_330", exp_res, 6);
    directed(1, 1, 0, 2, 0);
    directed(0, 1, 0, 1, 0);
    directed(1, 0, 0, 1, 0);
    directed(2, 3, 0, 1, 1);
    directed(3, 3, 1, 3, 1);
    check("pin_model_331", exp_res, 7);
    directed(1, 1, 1, 3, 0);
    directed(0, 1, 1, 2, 0);
    directed(1, 0, 1, 2, 0);
    directed(2, 3, 1, 2, 1);

    // Hold: invalid input with new operands must not disturb the result.
    directed(1, 1, 0, 2, 0);
    drive(3, 3, 0, 1'b0);
    @(posedge clk);
    #1;
    check("hold_sum",   int'(Sum),       2);
    check("hold_cout",  int'(Cout),      0);
    check("hold_valid", int'(out_valid), 0);
    check("pin_model_hold", exp_res, 2);

    // Exhaustive back-to-back stream; the compare process checks every cycle.
    for (int i = 0; i < 32; i++) drive(i % 4, (i / 4) % 4, i / 16, 1'b1);
    drive(0, 0, 0, 1'b0);

    // Mid-stream reset between two valid inputs.
    drive(3, 2, 1, 1'b1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_sum",   int'(Sum),       0);
    check("mid_rst_cout",  int'(Cout),      0);
    check("mid_rst_valid", int'(out_valid), 0);
    #1 rst = 1'b0;
    directed(2, 3, 1, 2, 1);

    // Randomized traffic with occasional reset pulses.
    for (int i = 0; i < 400; i++) begin
      drive(int'($urandom_range(3)), int'($urandom_range(3)), int'($urandom_range(1)),
            ($urandom_range(3) != 0));
      if ($urandom_range(40) == 0) begin
        #2 rst = 1'b1;
        #3 rst = 1'b0;
      end
    end
    drive(0, 0, 0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checking = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
